vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster generator that replaces the fixed 640x480 timing block. It produces sync, data-enable and frame/line markers from programmable porch and pulse widths. It also issues per-pixel coordinate requests to an upstream pixel source with a fixed, parametrised latency and realigns the returned colour with the delayed sync. It sits between the game/graphics logic and the board's VGA DAC pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync pulse and back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync pulse and back porch in lines
- HS_POL / VS_POL, 0 / 0, active sync level (0 = active-low)
- COLOR_W, 4, bits per colour channel
- PIPE, 2, pixel-source latency in cycles (0..7)

Ports:
- vgaclk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  run enable; low freezes the counters and the pipeline
- pix_req  out  1  requested pixel is in the active region
- pix_x  out  $clog2(H_ACTIVE)  requested column, valid when pix_req is high
- pix_y  out  $clog2(V_ACTIVE)  requested row, valid when pix_req is high
- pix_r / pix_g / pix_b  in  COLOR_W each  colour returned PIPE cycles after the request
- hsync / vsync  out  1  sync outputs at the HS_POL / VS_POL levels
- de  out  1  active-video flag, aligned with the colour outputs
- red / green / blue  out  COLOR_W each  DAC colour; forced to 0 whenever de is 0
- frame_start  out  1  one-cycle pulse on the first active pixel of a frame (output-aligned)
- line_start  out  1  one-cycle pulse on the first active pixel of each active line (output-aligned)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is formed the same way from the V parameters.
- hc counts 0..H_TOTAL-1. On wrap, hc returns to 0 and vc increments. When vc is at V_TOTAL-1 and hc wraps, vc also returns to 0.
- Region order within a line and within a frame: active, front porch, sync, back porch.
- Sync is asserted for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. The vertical sync window is defined the same way on vc.
- pix_req = (hc < H_ACTIVE) && (vc < V_ACTIVE). It is combinational from the counters. pix_x = hc and pix_y = vc when pix_req is high; otherwise pix_x and pix_y are 0.
- Raw hsync, vsync and de pass through a PIPE-stage shift register and then one output register.
- Colour inputs are registered into red/green/blue in the same output stage and gated by the delayed de.
- en low: counters, shift register and outputs all hold their values. pix_req is forced to 0.
- Counter widths are $clog2(H_TOTAL) and $clog2(V_TOTAL). No counter may overflow past its total.

## Timing
- Reset values:
  - hc = vc = 0
  - every shift-register stage holds blank (sync inactive, de 0)
  - hsync = ~HS_POL, vsync = ~VS_POL
  - de, frame_start, line_start, red, green, blue all 0
- Latency: a request at cycle t appears on de/red/green/blue/hsync/vsync at cycle t+PIPE+1.
- PIPE = 0: colour is sampled in the same cycle as the request.
- The first request after reset is (0,0) on the first enabled cycle. frame_start and line_start fire PIPE+1 cycles later.
- Reset asserted mid-line: all outputs go to their reset values asynchronously. On release, the raster restarts at (0,0).

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - adds input test_mode (1 bit)
  - when test_mode is 1, pix_r/g/b are ignored and the colour comes from 8 internal vertical bars
  - the bar index increments every H_ACTIVE/8 columns; bar[2]→red all-ones, bar[1]→green all-ones, bar[0]→blue all-ones
  - the pattern is generated at request time and passes through the same PIPE delay, so alignment is unchanged
- VGA_TEST_PATTERN_EN undefined: no test_mode port and no pattern logic.

## Structure
- vga_pkg holds:
  - default timing localparams for 640x480@60
  - a function that computes the totals
  - the rgb_t packed struct parametrised on COLOR_W (via a typedef in the module)
- One sub-module, vga_axis_counter:
  - parameters ACTIVE / FP / SYNC / BP
  - ports: count, wrap pulse, active flag, sync flag
  - instantiated twice: horizontal, and vertical advanced by the horizontal wrap

## Test plan
- Default parameters, en=1, run 2 frames:
  - hsync low for exactly 96 cycles, period 800
  - vsync low for 2 lines, period 525 lines = 420000 cycles
  - de high for 640x480 cycles per frame
- PIPE=2 with a source returning pix_r = pix_x[3:0]:
  - the output red on the first active pixel of each line is 0
  - the 16th active pixel shows 15
  - de rises 3 cycles after pix_req rises
- HS_POL=1, VS_POL=1: sync outputs are inverted relative to the default run, and their reset values are 0.
- Deassert en for 50 cycles mid-line at hc=300: counters hold; on re-enable, resume at hc=300 with no extra or dropped pixels in the line.
- Assert rst at hc=700, vc=200:
  - all outputs return to their reset values immediately
  - after release, frame_start fires PIPE+1 cycles after the first enabled cycle
- With VGA_TEST_PATTERN_EN and test_mode=1: columns 0..79 are black, columns 80..159 are blue 15, and columns 560..639 are white.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing defaults and helpers for the VGA raster generator
// Purpose: default 640x480@60 timing constants and the line/frame total helper.
// Ports: none (package).
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Length of a full line (or frame) in pixels (or lines).
  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis counter with region decode
// Purpose: counts 0..ACTIVE+FP+SYNC+BP-1 and decodes the active and sync regions.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-low reset
//   step   in   advance the count by one this cycle
//   count  out  current position on the axis
//   wrap   out  step taken on the last position (count returns to 0)
//   active out  count is in the active region
//   sync   out  count is in the sync window
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int W      = $clog2(vga_total(ACTIVE, FP, SYNC, BP))
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam int TOTAL = vga_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  assign wrap   = step && (count == LAST);
  // Compare as int so a window ending exactly at 2**W cannot alias to 0.
  assign active = int'(count) < ACTIVE;
  assign sync   = (int'(count) >= ACTIVE + FP) && (int'(count) < ACTIVE + FP + SYNC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster generator with pixel-source realignment
// Purpose: drives hsync/vsync/de and colour to the DAC, requests pixels upstream and
//   realigns the returned colour, which arrives PIPE cycles after each request.
// Optional feature macro: VGA_TEST_PATTERN_EN (adds test_mode and 8 vertical colour bars).
// Ports:
//   vgaclk                in   pixel clock
//   rst                   in   asynchronous active-low reset
//   en                    in   run enable; low freezes counters and pipeline
//   test_mode             in   (VGA_TEST_PATTERN_EN only) select internal colour bars
//   pix_req               out  requested pixel is in the active region
//   pix_x / pix_y         out  requested column / row, 0 when pix_req is low
//   pix_r / pix_g / pix_b in   colour returned PIPE cycles after the request
//   hsync / vsync         out  sync at HS_POL / VS_POL active level
//   de                    out  active video, aligned with the colour outputs
//   red / green / blue    out  DAC colour, 0 whenever de is 0
//   frame_start           out  pulse on the first active pixel of a frame
//   line_start            out  pulse on the first active pixel of each active line
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 4,
  parameter int PIPE     = 2
) (
  input  logic                        vgaclk,
  input  logic                        rst,
  input  logic                        en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                        test_mode,
`endif
  output logic                        pix_req,
  output logic [$clog2(H_ACTIVE)-1:0] pix_x,
  output logic [$clog2(V_ACTIVE)-1:0] pix_y,
  input  logic [COLOR_W-1:0]          pix_r,
  input  logic [COLOR_W-1:0]          pix_g,
  input  logic [COLOR_W-1:0]          pix_b,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        de,
  output logic [COLOR_W-1:0]          red,
  output logic [COLOR_W-1:0]          green,
  output logic [COLOR_W-1:0]          blue,
  output logic                        frame_start,
  output logic                        line_start
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // One delay-line slot; all-zero is the blank state (sync flags are active-high here).
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic ls;
`ifdef VGA_TEST_PATTERN_EN
    logic tm;
    rgb_t tp;
`endif
  } stage_t;

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  logic frame_pend;
  stage_t raw, dly;
  rgb_t src;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)
  ) u_h (
    .clk(vgaclk), .rst(rst), .step(en),
    .count(hc), .wrap(h_wrap), .active(h_act), .sync(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)
  ) u_v (
    .clk(vgaclk), .rst(rst), .step(h_wrap),
    .count(vc), .wrap(v_wrap), .active(v_act), .sync(v_sync)
  );

  assign pix_req = en && h_act && v_act;
  assign pix_x   = pix_req ? XW'(hc) : '0;
  assign pix_y   = pix_req ? YW'(vc) : '0;

  // Armed at reset and at every frame wrap; the next requested pixel is the frame's first.
  always_ff @(posedge vgaclk or negedge rst) begin
    if (!rst) begin
      frame_pend <= 1'b1;
    end else if (v_wrap) begin
      frame_pend <= 1'b1;
    end else if (pix_req) begin
      frame_pend <= 1'b0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  assign bar = 3'(int'(hc) / (H_ACTIVE / 8));
`endif

  always_comb begin
    raw    = '0;
    raw.hs = h_sync;
    raw.vs = v_sync;
    raw.de = h_act && v_act;
    raw.fs = frame_pend && h_act && v_act;
    raw.ls = (hc == '0) && v_act;
`ifdef VGA_TEST_PATTERN_EN
    raw.tm   = test_mode;
    raw.tp.r = {COLOR_W{bar[2]}};
    raw.tp.g = {COLOR_W{bar[1]}};
    raw.tp.b = {COLOR_W{bar[0]}};
`endif
  end

  // Delay the raster markers by the pixel-source latency.
  generate
    if (PIPE == 0) begin : g_nopipe
      assign dly = raw;
    end else begin : g_pipe
      stage_t sr [PIPE];
      always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < PIPE; i++) sr[i] <= '0;
        end else if (en) begin
          sr[0] <= raw;
          for (int i = 1; i < PIPE; i++) sr[i] <= sr[i-1];
        end
      end
      assign dly = sr[PIPE-1];
    end
  endgenerate

  always_comb begin
    src.r = pix_r;
    src.g = pix_g;
    src.b = pix_b;
`ifdef VGA_TEST_PATTERN_EN
    if (dly.tm) src = dly.tp;
`endif
  end

  always_ff @(posedge vgaclk or negedge rst) begin
    if (!rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else if (en) begin
      hsync       <= dly.hs ? HS_POL : ~HS_POL;
      vsync       <= dly.vs ? VS_POL : ~VS_POL;
      de          <= dly.de;
      frame_start <= dly.fs;
      line_start  <= dly.ls;
      red         <= dly.de ? src.r : '0;
      green       <= dly.de ? src.g : '0;
      blue        <= dly.de ? src.b : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (two geometries)
module tb_vga_timing_gen;

  localparam int A_HA = 16, A_HFP = 2, A_HS = 3, A_HBP = 4;
  localparam int A_VA = 6,  A_VFP = 1, A_VS = 2, A_VBP = 2;
  localparam int A_PIPE = 2;
  localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
  localparam int A_FT = A_HT * (A_VA + A_VFP + A_VS + A_VBP);
  localparam int B_HA = 8, B_HFP = 1, B_HS = 2, B_HBP = 1;
  localparam int B_VA = 4, B_VFP = 1, B_VS = 1, B_VBP = 1;
  localparam int B_PIPE = 0;
  localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
  localparam int B_FT = B_HT * (B_VA + B_VFP + B_VS + B_VBP);
  localparam int TMN = 4096;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int pipe; bit hpol; bit vpol;
  } geom_t;

  localparam geom_t GA = '{ha: A_HA, hfp: A_HFP, hs: A_HS, hbp: A_HBP, va: A_VA, vfp: A_VFP,
                           vs: A_VS, vbp: A_VBP, pipe: A_PIPE, hpol: 1'b0, vpol: 1'b0};
  localparam geom_t GB = '{ha: B_HA, hfp: B_HFP, hs: B_HS, hbp: B_HBP, va: B_VA, vfp: B_VFP,
                           vs: B_VS, vbp: B_VBP, pipe: B_PIPE, hpol: 1'b1, vpol: 1'b1};

  typedef struct packed {
    logic req; logic [9:0] x; logic [9:0] y;
    logic hs; logic vs; logic de; logic fs; logic ls;
    logic [3:0] cr; logic [3:0] cg; logic [3:0] cb;
  } obs_t;

  logic vgaclk = 1'b0;
  logic rst, en, test_mode;

  logic a_req, a_hs, a_vs, a_de, a_fs, a_ls;
  logic [$clog2(A_HA)-1:0] a_x;
  logic [$clog2(A_VA)-1:0] a_y;
  logic [3:0] a_pr, a_pg, a_pb, a_red, a_green, a_blue;
  logic b_req, b_hs, b_vs, b_de, b_fs, b_ls;
  logic [$clog2(B_HA)-1:0] b_x;
  logic [$clog2(B_VA)-1:0] b_y;
  logic [3:0] b_pr, b_pg, b_pb, b_red, b_green, b_blue;

  int checks = 0;
  int errors = 0;
  int n;
  int salt, salt2;
  bit tm_hist [0:TMN-1];

  always #5 vgaclk = ~vgaclk;

  vga_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .PIPE(A_PIPE)
  ) dut_a (
    .vgaclk(vgaclk), .rst(rst), .en(en),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .pix_req(a_req), .pix_x(a_x), .pix_y(a_y),
    .pix_r(a_pr), .pix_g(a_pg), .pix_b(a_pb),
    .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .red(a_red), .green(a_green), .blue(a_blue),
    .frame_start(a_fs), .line_start(a_ls)
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4), .PIPE(B_PIPE)
  ) dut_b (
    .vgaclk(vgaclk), .rst(rst), .en(en),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .pix_req(b_req), .pix_x(b_x), .pix_y(b_y),
    .pix_r(b_pr), .pix_g(b_pg), .pix_b(b_pb),
    .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .red(b_red), .green(b_green), .blue(b_blue),
    .frame_start(b_fs), .line_start(b_ls)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Upstream source colour for an active pixel.
  function automatic logic [11:0] src_col(int x, int y);
    return {4'(x), 4'(y + salt), 4'(x ^ (y << 1) ^ salt2)};
  endfunction

  function automatic logic [11:0] bars(geom_t g, int x);
    logic [2:0] bar;
    bar = 3'(x / (g.ha / 8));
    return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
  endfunction

  function automatic int tot_h(geom_t g);
    return g.ha + g.hfp + g.hs + g.hbp;
  endfunction

  function automatic int tot_f(geom_t g);
    return tot_h(g) * (g.va + g.vfp + g.vs + g.vbp);
  endfunction

  // Colour the source presents at the edge that follows m enabled edges.
  function automatic logic [11:0] src_for(geom_t g, int m);
    int p, h, v;
    p = m - g.pipe;
    if (p < 0) return 12'($urandom);
    p = p % tot_f(g);
    h = p % tot_h(g);
    v = p / tot_h(g);
    if (h < g.ha && v < g.va) return src_col(h, v);
    return 12'($urandom);
  endfunction

  // Expected DUT view after m enabled edges: position m is requested, position m-1-pipe is shown.
  function automatic obs_t model(geom_t g, int m, bit en_v);
    obs_t e;
    int p, h, v, q;
    e = '0;
    p = m % tot_f(g);
    h = p % tot_h(g);
    v = p / tot_h(g);
    e.req = en_v && h < g.ha && v < g.va;
    if (e.req) begin
      e.x = 10'(h);
      e.y = 10'(v);
    end
    e.hs = !g.hpol;
    e.vs = !g.vpol;
    q = m - 1 - g.pipe;
    if (q >= 0) begin
      p = q % tot_f(g);
      h = p % tot_h(g);
      v = p / tot_h(g);
      if (h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hs) e.hs = g.hpol;
      if (v >= g.va + g.vfp && v < g.va + g.vfp + g.vs) e.vs = g.vpol;
      e.de = h < g.ha && v < g.va;
      e.fs = e.de && p == 0;
      e.ls = e.de && h == 0;
      if (e.de) {e.cr, e.cg, e.cb} = (q < TMN && tm_hist[q]) ? bars(g, h) : src_col(h, v);
    end
    return e;
  endfunction

  task automatic check_inst(input string nm, input geom_t g, input obs_t got);
    obs_t e;
    e = model(g, n, en);
    chk({nm, ".pix_req"}, 32'(got.req), 32'(e.req));
    chk({nm, ".pix_x"}, 32'(got.x), 32'(e.x));
    chk({nm, ".pix_y"}, 32'(got.y), 32'(e.y));
    chk({nm, ".hsync"}, 32'(got.hs), 32'(e.hs));
    chk({nm, ".vsync"}, 32'(got.vs), 32'(e.vs));
    chk({nm, ".de"}, 32'(got.de), 32'(e.de));
    chk({nm, ".frame_start"}, 32'(got.fs), 32'(e.fs));
    chk({nm, ".line_start"}, 32'(got.ls), 32'(e.ls));
    chk({nm, ".red"}, 32'(got.cr), 32'(e.cr));
    chk({nm, ".green"}, 32'(got.cg), 32'(e.cg));
    chk({nm, ".blue"}, 32'(got.cb), 32'(e.cb));
  endtask

  // Called at a falling edge: drive inputs, check, then take one rising edge.
  task automatic cycle(input bit en_v);
    obs_t oa, ob;
    en = en_v;
    if (n < TMN) tm_hist[n] = test_mode;
    {a_pr, a_pg, a_pb} = src_for(GA, n);
    {b_pr, b_pg, b_pb} = src_for(GB, n);
    #1;
    oa = '0;
    oa.req = a_req; oa.x = 10'(a_x); oa.y = 10'(a_y);
    oa.hs = a_hs; oa.vs = a_vs; oa.de = a_de; oa.fs = a_fs; oa.ls = a_ls;
    oa.cr = a_red; oa.cg = a_green; oa.cb = a_blue;
    ob = '0;
    ob.req = b_req; ob.x = 10'(b_x); ob.y = 10'(b_y);
    ob.hs = b_hs; ob.vs = b_vs; ob.de = b_de; ob.fs = b_fs; ob.ls = b_ls;
    ob.cr = b_red; ob.cg = b_green; ob.cb = b_blue;
    check_inst("a", GA, oa);
    check_inst("b", GB, ob);
    @(posedge vgaclk);
    if (en_v && rst) n++;
    @(negedge vgaclk);
  endtask

  initial begin
    int de_a, hs_a, vs_a, de_b, hs_b, vs_b, lat;
    salt  = int'($urandom_range(0, 15));
    salt2 = int'($urandom_range(0, 15));
    rst = 1'b0; en = 1'b0; test_mode = 1'b0; n = 0;
    a_pr = '0; a_pg = '0; a_pb = '0; b_pr = '0; b_pg = '0; b_pb = '0;
    @(negedge vgaclk);

    // Held in reset, with and without enable.
    repeat (3) cycle(1'b0);
    repeat (2) cycle(1'b1);
    rst = 1'b1;

    // First frame of A, then a counted frame window.
    repeat (A_FT) cycle(1'b1);
    de_a = 0; hs_a = 0; vs_a = 0; de_b = 0; hs_b = 0; vs_b = 0;
    for (int i = 0; i < A_FT; i++) begin
      cycle(1'b1);
      de_a += int'(a_de);
      hs_a += int'(a_hs == 1'b0);
      vs_a += int'(a_vs == 1'b0);
      if (a_ls) chk("a.line_first_red", 32'(a_red), 32'd0);
      if (i < 3 * B_FT) begin
        de_b += int'(b_de);
        hs_b += int'(b_hs == 1'b1);
        vs_b += int'(b_vs == 1'b1);
      end
    end
    chk("a.de_per_frame", de_a, A_HA * A_VA);
    chk("a.hsync_per_frame", hs_a, A_HS * (A_VA + A_VFP + A_VS + A_VBP));
    chk("a.vsync_per_frame", vs_a, A_VS * A_HT);
    chk("b.de_per_3frames", de_b, 3 * B_HA * B_VA);
    chk("b.hsync_per_3frames", hs_b, 3 * B_HS * (B_VA + B_VFP + B_VS + B_VBP));
    chk("b.vsync_per_3frames", vs_b, 3 * B_VS * B_HT);

    // Random enable pattern.
    repeat (400) cycle($urandom_range(0, 3) != 0);

    // Enable hold mid-line at column 10 of A.
    for (int k = 0; k < 2 * A_FT && !(((n % A_FT) % A_HT) == 10 && ((n % A_FT) / A_HT) < A_VA); k++)
      cycle(1'b1);
    en = 1'b1;
    #1;
    chk("a.hold_x_before", 32'(a_x), 32'd10);
    repeat (50) cycle(1'b0);
    en = 1'b1;
    #1;
    chk("a.hold_x_after", 32'(a_x), 32'd10);
    chk("a.hold_req_after", 32'(a_req), 32'd1);
    repeat (A_HT * 2) cycle(1'b1);

    // Reset in the sync region of line 3, then restart.
    for (int k = 0; k < 2 * A_FT && !(((n % A_FT) % A_HT) == A_HA + A_HFP + 1 && ((n % A_FT) / A_HT) == 3); k++)
      cycle(1'b1);
    rst = 1'b0;
    n = 0;
    repeat (3) cycle(1'b1);
    rst = 1'b1;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      if (a_fs) begin
        lat = k;
        break;
      end
      cycle(1'b1);
    end
    chk("a.frame_start_latency", lat, A_PIPE + 1);
    repeat (300) cycle($urandom_range(0, 4) != 0);

`ifdef VGA_TEST_PATTERN_EN
    test_mode = 1'b1;
    repeat (A_FT + 5) cycle(1'b1);
    test_mode = 1'b0;
    repeat (10) cycle(1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
